// File: rtl/dram_resp_arbiter_if.sv
// Per-hart DRAM request/response bundle between the cpummu harts (master)
// and the memory-side responder (slave). The stats port appears only when
// DRAM_RESP_STATS_EN is defined.
interface dram_resp_arbiter_if #(
    parameter int NHART = 2
);
    logic [32*NHART-1:0] w_dram_addr;
    logic [32*NHART-1:0] w_dram_wdata;
    logic [NHART-1:0]    w_dram_we_t;
    logic [NHART-1:0]    w_dram_le;
    logic [3*NHART-1:0]  w_dram_ctrl;
    logic [32*NHART-1:0] w_dram_odata;
    logic [NHART-1:0]    w_dram_busy;
    logic [31:0]         w_grant;
    logic                w_misalign;
`ifdef DRAM_RESP_STATS_EN
    logic [32*NHART-1:0] w_stat_cnt;

    modport master (
        output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        input  w_dram_odata, w_dram_busy, w_grant, w_misalign, w_stat_cnt
    );
    modport slave (
        input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        output w_dram_odata, w_dram_busy, w_grant, w_misalign, w_stat_cnt
    );
`else
    modport master (
        output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        input  w_dram_odata, w_dram_busy, w_grant, w_misalign
    );
    modport slave (
        input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        output w_dram_odata, w_dram_busy, w_grant, w_misalign
    );
`endif
endinterface

// File: rtl/dram_resp_arbiter.sv
// Memory-side responder for NHART per-hart DRAM ports sharing one word-wide
// backing store. Requests are latched into per-hart slots, served one at a
// time in round-robin order, LAT cycles after grant. Writes merge byte/half
// lanes into the addressed word; reads extract and sign/zero-extend.
// Optional macro DRAM_RESP_STATS_EN adds per-hart completion counters.
module dram_resp_arbiter #(
    parameter int NHART     = 2,
    parameter int MEM_WORDS = 4096,
    parameter int LAT       = 2
) (
    input  logic               CLK,
    input  logic               RST_X,
    dram_resp_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    gnt_q, gnt_d;
    logic [HW-1:0]    rr_q, rr_d;
    logic [NHART-1:0] pend_q, pend_d, cap;
    logic             misal_q;
    logic [31:0]      odata_q [NHART];

    logic [AW+1:0]    addr_q  [NHART];
    logic [31:0]      wdata_q [NHART];
    logic [2:0]       ctrl_q  [NHART];
    logic [NHART-1:0] we_q;

    logic [31:0]      mem [MEM_WORDS];

    logic             done, found;
    logic [HW-1:0]    sel;
    int               idx;
    logic [AW+1:0]    g_addr;
    logic [2:0]       g_ctrl;
    logic             g_we, g_mis;
    logic [1:0]       g_off;
    logic [AW-1:0]    g_widx;
    logic [31:0]      rd_word, wr_word, ld_val;

    // Replace the addressed lane(s) of a stored word with right-aligned store data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = old_w;
        case (sz)
            2'd0:    r[{off, 3'b000} +: 8]     = wd[7:0];
            2'd1:    r[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lane(s) out of a word and extend to 32 bits.
    function automatic logic [31:0] extract_lanes(input logic [31:0] w, input logic [1:0] sz,
                                                  input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            2'd0:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Capture new request pulses into free slots; release the slot that completes.
    always_comb begin
        cap    = (bus.w_dram_we_t | bus.w_dram_le) & ~pend_q;
        pend_d = pend_q | cap;
        if (done) pend_d[gnt_q] = 1'b0;
    end

    // Decode the granted slot: aligned-down lane offset, word index, RMW data.
    always_comb begin
        g_addr  = addr_q[gnt_q];
        g_ctrl  = ctrl_q[gnt_q];
        g_we    = we_q[gnt_q];
        g_mis   = ((g_ctrl[1:0] == 2'd1) && g_addr[0]) || (g_ctrl[1] && (g_addr[1:0] != 2'b00));
        case (g_ctrl[1:0])
            2'd0:    g_off = g_addr[1:0];
            2'd1:    g_off = {g_addr[1], 1'b0};
            default: g_off = 2'b00;
        endcase
        g_widx  = g_addr[AW+1:2];
        rd_word = mem[g_widx];
        wr_word = merge_lanes(rd_word, wdata_q[gnt_q], g_ctrl[1:0], g_off);
        ld_val  = extract_lanes(rd_word, g_ctrl[1:0], g_off, g_ctrl[2]);
    end

    // Round-robin pick in IDLE, access countdown in ACCESS, completion strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        done    = 1'b0;
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int k = 0; k < NHART; k++) begin
            idx = (int'(rr_q) + k) % NHART;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = HW'(idx);
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    cnt_d   = CW'(LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    rr_d    = (gnt_q == HW'(NHART - 1)) ? '0 : gnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible results; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            misal_q <= 1'b0;
            for (int h = 0; h < NHART; h++) odata_q[h] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            if (done && g_mis) misal_q <= 1'b1;
            if (done) odata_q[gnt_q] <= g_we ? 32'h0 : ld_val;
        end
    end

    // Slot payloads only matter while pending, so they carry no reset.
    always_ff @(posedge CLK) begin
        for (int h = 0; h < NHART; h++) begin
            if (cap[h]) begin
                addr_q[h]  <= bus.w_dram_addr[32*h +: AW+2];
                wdata_q[h] <= bus.w_dram_wdata[32*h +: 32];
                ctrl_q[h]  <= bus.w_dram_ctrl[3*h +: 3];
                we_q[h]    <= bus.w_dram_we_t[h];
            end
        end
    end

    // Backing store write at the completion edge of a granted store.
    always_ff @(posedge CLK) begin
        if (done && g_we) mem[g_widx] <= wr_word;
    end

`ifdef DRAM_RESP_STATS_EN
    logic [31:0] stat_q [NHART];

    // Per-hart completed-access counters, wrapping naturally at 2^32.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int h = 0; h < NHART; h++) stat_q[h] <= '0;
        end else if (done) begin
            stat_q[gnt_q] <= stat_q[gnt_q] + 32'd1;
        end
    end
`endif

    for (genvar h = 0; h < NHART; h++) begin : g_out
        assign bus.w_dram_odata[32*h +: 32] = odata_q[h];
`ifdef DRAM_RESP_STATS_EN
        assign bus.w_stat_cnt[32*h +: 32] = stat_q[h];
`endif
    end

    assign bus.w_dram_busy = pend_q;
    assign bus.w_grant     = 32'(gnt_q);
    assign bus.w_misalign  = misal_q;

endmodule

// File: tb/tb_dram_resp_arbiter.sv
// Randomized and directed bench for dram_resp_arbiter with a transaction-level
// reference model (byte-addressed memory, time-stamped service slots).
module tb_dram_resp_arbiter;
    localparam int NH  = 2;
    localparam int MW  = 4096;
    localparam int LAT = 2;
    localparam int MB  = MW * 4;

    logic CLK = 1'b0;
    logic RST_X = 1'b1;
    always #5 CLK = ~CLK;

    dram_resp_arbiter_if #(.NHART(NH)) bus ();

    dram_resp_arbiter #(.NHART(NH), .MEM_WORDS(MW), .LAT(LAT)) dut (
        .CLK  (CLK),
        .RST_X(RST_X),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NH-1:0] m_pend, pre;
    logic [NH-1:0] m_we;
    logic [31:0]   m_addr [NH];
    logic [31:0]   m_wd   [NH];
    logic [2:0]    m_ctl  [NH];
    logic [31:0]   m_odata[NH];
    logic [31:0]   m_cnt  [NH];
    logic [7:0]    mb     [MB];
    bit            m_serving, m_mis;
    int            m_g, m_rr;
    longint        m_now, m_fin;

    task automatic serve(input int h);
        int nb, base;
        logic [31:0] a, v;
        a = m_addr[h];
        case (m_ctl[h][1:0])
            2'd0: nb = 1;
            2'd1: begin nb = 2; if (a[0]) m_mis = 1'b1; a[0] = 1'b0; end
            default: begin nb = 4; if (a[1:0] != 2'b00) m_mis = 1'b1; a[1:0] = 2'b00; end
        endcase
        base = int'(a % MB);
        if (m_we[h]) begin
            for (int i = 0; i < nb; i++) mb[base + i] = m_wd[h][8*i +: 8];
            m_odata[h] = 32'h0;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base + i];
            if (nb < 4 && !m_ctl[h][2] && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            m_odata[h] = v;
        end
        m_cnt[h] = m_cnt[h] + 32'd1;
    endtask

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            m_pend = '0; m_serving = 1'b0; m_mis = 1'b0; m_g = 0; m_rr = 0; m_now = 0; m_fin = 0;
            for (int h = 0; h < NH; h++) begin m_odata[h] = 32'h0; m_cnt[h] = 32'h0; end
        end else begin
            pre = m_pend;
            m_now++;
            if (m_serving) begin
                if (m_now == m_fin) begin
                    serve(m_g);
                    m_pend[m_g] = 1'b0;
                    m_rr = (m_g + 1) % NH;
                    m_serving = 1'b0;
                end
            end else begin
                for (int k = 0; k < NH; k++) begin
                    if (!m_serving && pre[(m_rr + k) % NH]) begin
                        m_g = (m_rr + k) % NH;
                        m_serving = 1'b1;
                        m_fin = m_now + LAT;
                    end
                end
            end
            for (int h = 0; h < NH; h++) begin
                if ((bus.w_dram_we_t[h] || bus.w_dram_le[h]) && !pre[h]) begin
                    m_pend[h] = 1'b1;
                    m_we[h]   = bus.w_dram_we_t[h];
                    m_addr[h] = bus.w_dram_addr[32*h +: 32];
                    m_wd[h]   = bus.w_dram_wdata[32*h +: 32];
                    m_ctl[h]  = bus.w_dram_ctrl[3*h +: 3];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_busy", 32'(bus.w_dram_busy), 32'(m_pend));
            check("model_grant", bus.w_grant, 32'(m_g));
            check("model_misalign", 32'(bus.w_misalign), 32'(m_mis));
            for (int h = 0; h < NH; h++) begin
                check($sformatf("model_odata%0d", h), bus.w_dram_odata[32*h +: 32], m_odata[h]);
`ifdef DRAM_RESP_STATS_EN
                check($sformatf("model_stat%0d", h), bus.w_stat_cnt[32*h +: 32], m_cnt[h]);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int h, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] c);
        bus.w_dram_addr[32*h +: 32]  = a;
        bus.w_dram_wdata[32*h +: 32] = wd;
        bus.w_dram_ctrl[3*h +: 3]    = c;
        bus.w_dram_we_t[h]           = we;
        bus.w_dram_le[h]             = ~we;
    endtask

    task automatic clr_req();
        bus.w_dram_we_t = '0;
        bus.w_dram_le   = '0;
    endtask

    task automatic req(input int h, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] c);
        @(negedge CLK);
        set_req(h, we, a, wd, c);
        @(negedge CLK);
        clr_req();
    endtask

    task automatic wait_idle(input int h, output int cyc);
        cyc = 0;
        while (bus.w_dram_busy[h] && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        check("busy_drop", 32'(bus.w_dram_busy[h]), 32'h0);
    endtask

    initial begin
        int cyc;
        logic [31:0] r;
        bus.w_dram_addr = '0; bus.w_dram_wdata = '0; bus.w_dram_ctrl = '0;
        clr_req();
        #2 RST_X = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(bus.w_dram_busy), 32'h0);
        check("rst_grant", bus.w_grant, 32'h0);
        check("rst_misalign", 32'(bus.w_misalign), 32'h0);
        check("rst_odata0", bus.w_dram_odata[31:0], 32'h0);
        check("rst_odata1", bus.w_dram_odata[63:32], 32'h0);
        #2 RST_X = 1'b1;
        chk_en = 1'b1;

        // SW / LW round trip with latency
        req(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010); wait_idle(0, cyc); check("sw_lat", cyc, 3);
        req(0, 1'b0, 32'h100, 32'h0, 3'b010);        wait_idle(0, cyc); check("lw_lat", cyc, 3);
        check("lw_data", bus.w_dram_odata[31:0], 32'hDEADBEEF);

        // Byte store into zero word, then signed/unsigned/word loads
        req(0, 1'b1, 32'h100, 32'h0, 3'b010);  wait_idle(0, cyc);
        req(0, 1'b1, 32'h10C, 32'h0, 3'b010);  wait_idle(0, cyc);
        req(0, 1'b1, 32'h101, 32'h80, 3'b000); wait_idle(0, cyc);
        req(0, 1'b0, 32'h101, 32'h0, 3'b000);  wait_idle(0, cyc); check("lb", bus.w_dram_odata[31:0], 32'hFFFFFF80);
        req(0, 1'b0, 32'h101, 32'h0, 3'b100);  wait_idle(0, cyc); check("lbu", bus.w_dram_odata[31:0], 32'h00000080);
        req(0, 1'b0, 32'h100, 32'h0, 3'b010);  wait_idle(0, cyc); check("lw_byte", bus.w_dram_odata[31:0], 32'h00008000);

        // Hart1 access moves RR pointer back to 0, then contended loads
        req(1, 1'b1, 32'h200, 32'h12345678, 3'b010); wait_idle(1, cyc);
        @(negedge CLK);
        set_req(0, 1'b0, 32'h100, 32'h0, 3'b010);
        set_req(1, 1'b0, 32'h100, 32'h0, 3'b010);
        @(negedge CLK);
        clr_req();
        @(negedge CLK);
        check("rr_first_grant", bus.w_grant, 32'h0);
        wait_idle(1, cyc);
        check("rr_hart1_lat", cyc, 5);
        check("rr_second_grant", bus.w_grant, 32'h1);
        check("rr_odata1", bus.w_dram_odata[63:32], 32'h00008000);

        // Misaligned word load and address aliasing
        req(1, 1'b0, 32'h102, 32'h0, 3'b010); wait_idle(1, cyc);
        check("misal_data", bus.w_dram_odata[63:32], 32'h00008000);
        check("misal_flag", 32'(bus.w_misalign), 32'h1);
        req(0, 1'b1, 32'h4102, 32'hBEEF, 3'b001); wait_idle(0, cyc);
        req(0, 1'b0, 32'h102, 32'h0, 3'b101);     wait_idle(0, cyc); check("lhu", bus.w_dram_odata[31:0], 32'h0000BEEF);
        req(0, 1'b0, 32'h102, 32'h0, 3'b001);     wait_idle(0, cyc); check("lh", bus.w_dram_odata[31:0], 32'hFFFFBEEF);
        req(0, 1'b0, 32'h100, 32'h0, 3'b011);     wait_idle(0, cyc); check("alias_lw", bus.w_dram_odata[31:0], 32'hBEEF8000);

        // Second pulse while busy is ignored
        req(0, 1'b1, 32'h108, 32'hAAAA0001, 3'b010);
        req(0, 1'b1, 32'h108, 32'h55555555, 3'b010);
        wait_idle(0, cyc); check("dup_lat", cyc, 1);
        repeat (3) @(negedge CLK);
        check("dup_no_rerun", 32'(bus.w_dram_busy), 32'h0);
        req(0, 1'b0, 32'h108, 32'h0, 3'b010); wait_idle(0, cyc); check("dup_data", bus.w_dram_odata[31:0], 32'hAAAA0001);

        // Reset during ACCESS aborts the store
        req(1, 1'b1, 32'h10C, 32'h77, 3'b010);
        @(negedge CLK);
        #2 RST_X = 1'b0;
        #1;
        check("abort_busy", 32'(bus.w_dram_busy), 32'h0);
        check("abort_grant", bus.w_grant, 32'h0);
        check("abort_misalign", 32'(bus.w_misalign), 32'h0);
        @(negedge CLK);
        #2 RST_X = 1'b1;
        req(0, 1'b0, 32'h10C, 32'h0, 3'b010); wait_idle(0, cyc);
        check("post_rst_lat", cyc, 3);
        check("abort_no_write", bus.w_dram_odata[31:0], 32'h0);

        // Initialise the random region, then random traffic
        for (int w = 0; w < 8; w++) begin
            req(0, 1'b1, 32'h200 + 32'(4*w), 32'h0, 3'b010); wait_idle(0, cyc);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            clr_req();
            for (int h = 0; h < NH; h++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom();
                    set_req(h, 1'b0, {r[31:14], 9'h010, r[4:0]}, $urandom(), 3'($urandom_range(0, 7)));
                    bus.w_dram_we_t[h] = ($urandom_range(0, 2) != 0);
                    bus.w_dram_le[h]   = ($urandom_range(0, 1) == 0) || !bus.w_dram_we_t[h];
                end
            end
        end
        @(negedge CLK);
        clr_req();
        cyc = 0;
        while (bus.w_dram_busy != '0 && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        check("drain", 32'(bus.w_dram_busy), 32'h0);
        repeat (2) @(negedge CLK);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
